gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parameterised synchronous up/down counter that drives a Gray-coded count, one bit change per step.
- Sits directly upstream of the 4-bit Gray-to-binary converter and supplies its g input.
- Also exports the matching binary count, so the bench can compare the converter output against a golden value.
- Used as a Gray pointer source for later clock-domain-crossing blocks.

Parameters:
- W, 4, counter width in bits (W >= 2).
- RST_VAL, 0, binary count loaded on reset (0 <= RST_VAL <= 2^W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per clk edge when high.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous load strobe.
- load_bin  input  W  binary value to load.
- g  output  W  registered Gray count.
- bin  output  W  registered binary count.
- tc  output  1  terminal count: bin==2^W-1 when up=1, bin==0 when up=0 (combinational from bin and up).
- err  output  1  Gray step error flag (see Optional Feature).

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- State is one W-bit binary register cnt. Outputs: bin = cnt, and g = cnt ^ (cnt >> 1).
- g is registered from next-state logic in the same edge as cnt, so g and bin always describe the same count. There is no combinational path from inputs to g or bin.
- Reset, per edge with rst=1:
  - cnt <= RST_VAL, so g <= RST_VAL ^ (RST_VAL >> 1).
  - err <= 0.
  - rst overrides load and en.
- Priority per edge: rst > load > en.
  - load=1: cnt <= load_bin, regardless of en and up.
  - load=0, en=1, up=1: cnt <= cnt + 1, modulo 2^W. 2^W-1 wraps to 0.
  - load=0, en=1, up=0: cnt <= cnt - 1, modulo 2^W. 0 wraps to 2^W-1.
  - load=0, en=0: hold. g and bin unchanged.
- Latency: one cycle from en/load sampled to new g/bin visible.
- tc follows up combinationally. Changing up changes tc in the same cycle without changing the count.
- Reset asserted mid-count: next edge gives RST_VAL regardless of the other inputs. Counting resumes on the first edge with rst=0.
- Wrap steps (all-ones<->0) are legal single-bit Gray transitions. For W=4, g goes 1000 -> 0000.
- Toggling up every cycle with en=1 oscillates between two adjacent values. Each step is still a single Gray bit change.

Optional Feature:
- Macro: GRAY_COUNTER_STEP_CHECK_EN.
- Defined: a checker registers the previous g and a flag step_d. step_d=1 when the last edge was a count step, i.e. en=1, load=0, rst=0.
  - When step_d=1 and popcount(g ^ g_prev) != 1, err is set.
  - err is sticky until rst. Loads and holds never set err.
- Not defined: err is tied to 0 and no checker logic is built.

Decomposition:
- Package gray_pkg holds:
  - constant GRAY_W_DEFAULT = 4.
  - function bin2gray(W-bit) returning bin ^ (bin >> 1).
  - function popcount used by the checker.
- One natural sub-module: bin_to_gray, combinational, W-parameterised. It is the inverse partner of the existing Gray-to-binary converter and is instantiated on the next-state path.
- The counter FSM stays in gray_counter. It has no explicit state enum: the state is cnt.

Test Plan:
- Reset: W=4, RST_VAL=0, rst=1 for 2 cycles, en=1 -> g=0000, bin=0000, err=0; tc=1 only while up=0.
- Full up sweep: en=1, up=1 for 16 cycles from 0.
  - Expect g sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then wrap to 0000.
  - tc=1 exactly when g=1000.
  - Chain into Gray_to_Binary: its b output equals bin every cycle.
- Down wrap: load_bin=0001, load=1 for one cycle, then en=1, up=0 -> bin 0001, 0000, 1111; g 0001, 0000, 1000; tc=1 at bin=0000.
- Priority: the same edge has load=1, load_bin=1010, en=1, up=1 -> bin=1010, g=1111 (load wins). Next edge has rst=1, load=1 -> bin=0000.
- Hold and direction toggle: en=0 for 5 cycles at bin=0110 -> g stays 0101. Then en=1 with up alternating 1,0,1 -> bin 0111, 0110, 0111.
- With GRAY_COUNTER_STEP_CHECK_EN defined: run the full sweep -> err stays 0. A load jump from 0000 to 0101 -> err stays 0. Force cnt via hierarchical deposit to skip a value during a count step -> err=1 and stays 1 until rst.

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared constants and helpers for the Gray counter slice: Gray encoding and
// the bit-count used by the optional step checker.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  // Operates on a fixed maximum width; callers zero-extend and truncate.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_W_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_counter_bin_to_gray.sv
// Combinational binary-to-Gray encoder, the inverse partner of the Gray-to-binary
// converter downstream; sits on the counter's next-state path.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  logic [GRAY_W_MAX-1:0] w_gray_full;

  // Zero-extension keeps the MSB of the truncated result equal to i_bin[W-1].
  assign w_gray_full = bin2gray(GRAY_W_MAX'(i_bin));
  assign o_gray      = w_gray_full[W-1:0];

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered Gray and binary outputs, synchronous load and
// terminal count. Define GRAY_COUNTER_STEP_CHECK_EN to build the Gray step checker.
module gray_counter
  import gray_pkg::*;
#(
  parameter int W       = GRAY_W_DEFAULT,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_bin,
  output logic [W-1:0] g,
  output logic [W-1:0] bin,
  output logic         tc,
  output logic         err
);

  localparam logic [W-1:0]          RST_BIN  = W'(RST_VAL);
  localparam logic [GRAY_W_MAX-1:0] RST_GFUL = bin2gray(GRAY_W_MAX'(RST_BIN));
  localparam logic [W-1:0]          RST_GRAY = RST_GFUL[W-1:0];

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_g;
  logic [W-1:0] w_cnt_next;
  logic [W-1:0] w_g_next;

  // NOTE: every path assigns w_cnt_next via the leading default, so no latch is inferred.
  always_comb begin
    w_cnt_next = r_cnt;
    if (load) begin
      w_cnt_next = load_bin;
    end else if (en) begin
      w_cnt_next = up ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end

  bin_to_gray #(.W(W)) u_bin_to_gray (
    .i_bin  (w_cnt_next),
    .o_gray (w_g_next)
  );

  // NOTE: non-blocking assignments so r_cnt and r_g update together from the same next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RST_BIN;
      r_g   <= RST_GRAY;
    end else begin
      r_cnt <= w_cnt_next;
      r_g   <= w_g_next;
    end
  end

  assign bin = r_cnt;
  assign g   = r_g;
  assign tc  = up ? (r_cnt == {W{1'b1}}) : (r_cnt == '0);

`ifdef GRAY_COUNTER_STEP_CHECK_EN
  logic [W-1:0] r_g_prev;
  logic         r_step_d;
  logic         r_err;
  logic         w_step_bad;

  // Only count steps are judged; loads and holds may legally jump or repeat.
  assign w_step_bad = r_step_d && (popcount(GRAY_MAX_EXT(r_g ^ r_g_prev)) != 1);

  function automatic logic [GRAY_W_MAX-1:0] GRAY_MAX_EXT(input logic [W-1:0] v);
    return GRAY_W_MAX'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_prev <= RST_GRAY;
      r_step_d <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_g_prev <= r_g;
      r_step_d <= en && !load;
      if (w_step_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (W=4, RST_VAL=0).
module tb_gray_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] g;
  logic [W-1:0] bin;
  logic         tc;
  logic         err;

  int n_checks;
  int n_errors;

  gray_counter #(.W(W), .RST_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .g        (g),
    .bin      (bin),
    .tc       (tc),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs are changed #1 after the edge, outputs are sampled there as well.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] gv);
    logic [W-1:0] b;
    b[W-1] = gv[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gv[i];
    end
    return b;
  endfunction

  logic [W-1:0] gray_tab [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_bin = '0;

    // Reset
    #1;
    step(); step();
    check("rst_g",   32'(g),   32'h0);
    check("rst_bin", 32'(bin), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_tc_up", 32'(tc), 32'h0);
    up = 1'b0; #1;
    check("rst_tc_dn", 32'(tc), 32'h1);
    up = 1'b1; #1;

    // Full up sweep with wrap
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sweep_g%0d", i),   32'(g),   32'(gray_tab[i]));
      check($sformatf("sweep_bin%0d", i), 32'(bin), i);
      check($sformatf("sweep_tc%0d", i),  32'(tc),  (i == 15) ? 1 : 0);
      check($sformatf("sweep_g2b%0d", i), 32'(gray2bin(g)), 32'(bin));
      check($sformatf("sweep_err%0d", i), 32'(err), 32'h0);
      step();
    end
    check("wrap_g",   32'(g),   32'h0);
    check("wrap_bin", 32'(bin), 32'h0);

    // Down wrap
    load = 1'b1; load_bin = 4'b0001; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0; #1;
    check("dn_bin0", 32'(bin), 32'h1);
    check("dn_g0",   32'(g),   32'h1);
    check("dn_tc0",  32'(tc),  32'h0);
    step();
    check("dn_bin1", 32'(bin), 32'h0);
    check("dn_g1",   32'(g),   32'h0);
    check("dn_tc1",  32'(tc),  32'h1);
    step();
    check("dn_bin2", 32'(bin), 32'hF);
    check("dn_g2",   32'(g),   32'h8);
    check("dn_tc2",  32'(tc),  32'h0);

    // Priority: load over count, reset over load
    load = 1'b1; load_bin = 4'b1010; en = 1'b1; up = 1'b1;
    step();
    check("pri_load_bin", 32'(bin), 32'hA);
    check("pri_load_g",   32'(g),   32'hF);
    rst = 1'b1;
    step();
    check("pri_rst_bin", 32'(bin), 32'h0);
    check("pri_rst_g",   32'(g),   32'h0);
    rst = 1'b0;

    // Hold then direction toggle
    load = 1'b1; load_bin = 4'b0110;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_g%0d", i),   32'(g),   32'h5);
      check($sformatf("hold_bin%0d", i), 32'(bin), 32'h6);
    end
    en = 1'b1; up = 1'b1;
    step();
    check("tog_bin0", 32'(bin), 32'h7);
    check("tog_g0",   32'(g),   32'h4);
    up = 1'b0;
    step();
    check("tog_bin1", 32'(bin), 32'h6);
    check("tog_g1",   32'(g),   32'h5);
    up = 1'b1;
    step();
    check("tog_bin2", 32'(bin), 32'h7);
    check("tog_g2",   32'(g),   32'h4);
    check("tog_err",  32'(err), 32'h0);

`ifdef GRAY_COUNTER_STEP_CHECK_EN
    // Checker: legal load jump must not flag
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; load = 1'b1; load_bin = 4'b0101;
    step();
    load = 1'b0;
    step(); step();
    check("chk_load_err", 32'(err), 32'h0);

    // Checker: a deposited skip during a count step must flag and stick
    load = 1'b1; load_bin = 4'b0011;
    step();
    load = 1'b0;
    dut.r_cnt = 4'b0101;
    en = 1'b1; up = 1'b1;
    step();
    en = 1'b0;
    step();
    check("chk_skip_err", 32'(err), 32'h1);
    step(); step();
    check("chk_sticky_err", 32'(err), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("chk_rst_err", 32'(err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
